// File: rtl/vmicro16_apb_rr_arbiter.sv
// vmicro16_apb_rr_arbiter: round-robin arbiter funnelling several APB masters onto one shared APB bus with an access timeout
module vmicro16_apb_rr_arbiter #(
  parameter int MASTER_PORTS = 4,
  parameter int BUS_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic                               M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [DATA_WIDTH-1:0]              M_PRDATA,
  input  logic                               M_PREADY,
  output logic [$clog2(MASTER_PORTS)-1:0]    grant,
  output logic                               grant_valid,
  output logic                               timeout_err
);
  localparam int GW = $clog2(MASTER_PORTS);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q;
  logic [GW-1:0] grant_q, rr_ptr_q, pick;
  logic [7:0] cnt_q;
  logic [MASTER_PORTS-1:0] done_q, elig;
  logic abort_q, any, busy, tmo, fin, live;
  logic [GW:0] sum;
  // the master that just finished is masked for one IDLE cycle so a late-dropping PSEL cannot repeat
  assign elig = S_PSELx & ~done_q;
  always_comb begin
    pick = '0;
    any = 1'b0;
    sum = '0;
    for (int i = MASTER_PORTS-1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
      sum = sum >= (GW+1)'(MASTER_PORTS) ? sum - (GW+1)'(MASTER_PORTS) : sum;
      if (elig[sum[GW-1:0]]) begin
        pick = sum[GW-1:0];
        any = 1'b1;
      end
    end
  end
  assign busy = state_q != IDLE;
  assign tmo = state_q == ACCESS && !M_PREADY && cnt_q == 8'(TIMEOUT_CYCLES-1);
  assign fin = state_q == ACCESS && (M_PREADY || tmo);
  assign live = reset && fin && S_PSELx[grant_q] && !abort_q;
  assign grant = grant_q;
  assign grant_valid = busy;
  assign M_PSELx = busy;
  assign M_PENABLE = state_q == ACCESS;
  assign M_PADDR = busy ? S_PADDR[grant_q*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign M_PWRITE = busy && S_PWRITE[grant_q];
  assign M_PWDATA = busy ? S_PWDATA[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign timeout_err = reset && tmo;
  always_comb begin
    S_PREADY = '0;
    S_PRDATA = '0;
    S_PREADY[grant_q] = live;
    S_PRDATA[grant_q*DATA_WIDTH +: DATA_WIDTH] = live ? (tmo ? ERR_DATA : M_PRDATA) : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      cnt_q <= '0;
      done_q <= '0;
      abort_q <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (any) begin
            grant_q <= pick;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q <= '0;
          abort_q <= abort_q | ~S_PSELx[grant_q];
          state_q <= ACCESS;
        end
        default: begin
          abort_q <= abort_q | ~S_PSELx[grant_q];
          cnt_q <= fin ? '0 : cnt_q + 8'd1;
          if (fin) begin
            state_q <= IDLE;
            rr_ptr_q <= grant_q == GW'(MASTER_PORTS-1) ? '0 : grant_q + 1'b1;
            done_q <= MASTER_PORTS'(1) << grant_q;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// tb_vmicro16_apb_rr_arbiter: directed self-checking bench for the APB round-robin arbiter
module tb_vmicro16_apb_rr_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [63:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic [3:0] S_PWRITE, S_PSELx, S_PREADY;
  logic [15:0] M_PADDR, M_PWDATA, M_PRDATA;
  logic M_PWRITE, M_PSELx, M_PENABLE, M_PREADY;
  logic [1:0] grant;
  logic grant_valid, timeout_err;
  int checks = 0;
  int failures = 0;

  vmicro16_apb_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .grant(grant), .grant_valid(grant_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    S_PSELx = '0;
    S_PWRITE = '0;
    S_PADDR = '0;
    S_PWDATA = '0;
    M_PREADY = 1'b0;
    M_PRDATA = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // entered at the start of a SETUP cycle, returns in the IDLE cycle after completion
  task automatic xfer(input int m, input logic [15:0] rd, input bit keep);
    #1;
    check("setup_phase", {M_PSELx, M_PENABLE, grant_valid}, 3'b101);
    check("setup_grant", grant, m);
    check("setup_addr", M_PADDR, S_PADDR[16*m +: 16]);
    check("setup_rdy", S_PREADY, 0);
    tick();
    M_PREADY = 1'b1;
    M_PRDATA = rd;
    #1;
    check("access_phase", {M_PSELx, M_PENABLE}, 2'b11);
    check("access_rdy", S_PREADY, 64'(1) << m);
    check("access_data", S_PRDATA, 64'(rd) << (16*m));
    tick();
    M_PREADY = 1'b0;
    M_PRDATA = '0;
    if (!keep) S_PSELx[m] = 1'b0;
    #1;
    check("idle_gap", grant_valid, 0);
    check("idle_rdy", S_PREADY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    check("rst_outs", {grant_valid, M_PSELx, M_PENABLE, timeout_err, grant}, 0);
    check("rst_rdy", S_PREADY, 0);
    check("rst_rdata", S_PRDATA, 0);
    check("rst_addr", M_PADDR, 0);
    // single read from master 2
    S_PADDR[32 +: 16] = 16'h0040;
    S_PSELx = 4'b0100;
    #1;
    check("req_idle", grant_valid, 0);
    tick();
    xfer(2, 16'h1234, 0);
    check("idle_addr", M_PADDR, 0);
    // pointer now at 3: 3 beats 0
    S_PSELx = 4'b1001;
    tick();
    xfer(3, 16'h3333, 0);
    tick();
    xfer(0, 16'h5A5A, 0);
    // move pointer to 3 again, then master 2 re-requests in the masked cycle
    S_PSELx = 4'b0100;
    tick();
    xfer(2, 16'h2222, 0);
    S_PSELx = 4'b0100;
    tick();
    check("masked_idle", grant_valid, 0);
    tick();
    check("regrant", grant, 2);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_access", M_PENABLE, 1);
    tick();
    check("rst_abandon", {M_PSELx, grant_valid}, 0);
    check("rst_abandon_rdy", S_PREADY, 0);
    reset = 1'b1;
    S_PSELx = 4'b1100;
    tick();
    xfer(2, 16'h0202, 0);
    tick();
    xfer(3, 16'h0303, 0);
    // four simultaneous requests from reset
    do_reset();
    S_PSELx = 4'hF;
    tick();
    xfer(0, 16'hA000, 0);
    tick();
    xfer(1, 16'hA001, 0);
    tick();
    xfer(2, 16'hA002, 0);
    tick();
    xfer(3, 16'hA003, 0);
    // master 1 lingers one cycle after its ready while master 3 waits
    do_reset();
    S_PSELx = 4'b1010;
    tick();
    xfer(1, 16'h1111, 1);
    tick();
    S_PSELx[1] = 1'b0;
    xfer(3, 16'h3131, 0);
    S_PSELx = 4'b0010;
    tick();
    xfer(1, 16'h1212, 1);
    tick();
    S_PSELx[1] = 1'b0;
    #1;
    check("no_dup", grant_valid, 0);
    // timeout with no slave response
    do_reset();
    S_PSELx = 4'b0001;
    tick();
    #1;
    check("to_setup", {M_PSELx, M_PENABLE}, 2'b10);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("to_wait", {M_PENABLE, timeout_err, S_PREADY}, 6'b100000);
    end
    tick();
    check("to_fire", {timeout_err, S_PREADY}, 5'b10001);
    check("to_data", S_PRDATA, 64'hDEAD);
    tick();
    S_PSELx = '0;
    check("to_pulse", {timeout_err, grant_valid}, 0);
    // write from master 0
    do_reset();
    S_PADDR[15:0] = 16'h0010;
    S_PWDATA[15:0] = 16'hBEEF;
    S_PWRITE = 4'b0001;
    S_PSELx = 4'b0001;
    tick();
    check("wr_setup", {M_PWRITE, M_PWDATA, M_PADDR}, {1'b1, 16'hBEEF, 16'h0010});
    tick();
    M_PREADY = 1'b1;
    #1;
    check("wr_access", {M_PWRITE, M_PWDATA, M_PADDR, S_PREADY}, {1'b1, 16'hBEEF, 16'h0010, 4'b0001});
    tick();
    M_PREADY = 1'b0;
    S_PSELx = '0;
    check("wr_idle", {M_PWRITE, M_PWDATA, M_PADDR}, 0);
    // abort: master 1 drops during SETUP
    do_reset();
    S_PSELx = 4'b0010;
    tick();
    S_PSELx = '0;
    check("ab_setup", M_PSELx, 1);
    tick();
    M_PREADY = 1'b1;
    M_PRDATA = 16'h7777;
    #1;
    check("ab_access", M_PENABLE, 1);
    check("ab_rdy", S_PREADY, 0);
    check("ab_data", S_PRDATA, 0);
    tick();
    M_PREADY = 1'b0;
    M_PRDATA = '0;
    S_PSELx = 4'b0101;
    tick();
    xfer(2, 16'h4242, 0);
    tick();
    xfer(0, 16'h4040, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
